// File: rtl/baud_pkg.sv
// Shared types and constants for the baud tick generator.
// Holds the FSM state type, default sizing and the oversample index width helper.
package baud_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 20;
  localparam int OSR_DEF   = 16;

  // Width of an index counting 0..n-1; never narrower than one bit.
  function automatic int os_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle of the baud tick generator.
// BAUD_MID_TICK_EN adds the mid_tick signal to the bundle and both modports.
interface baud_tick_gen_if
  import baud_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OSR   = OSR_DEF
);
  localparam int OS_W = os_width(OSR);

  logic             en;
  logic             load;
  logic [CNT_W-1:0] divisor;
  logic             os_tick;
  logic             bit_tick;
  logic             div_err;
  logic [CNT_W-1:0] count;
  logic [OS_W-1:0]  os_cnt;
`ifdef BAUD_MID_TICK_EN
  logic             mid_tick;
`endif

  modport master (
    output en, load, divisor,
    input  os_tick, bit_tick, div_err, count, os_cnt
`ifdef BAUD_MID_TICK_EN
    , mid_tick
`endif
  );

  modport slave (
    input  en, load, divisor,
    output os_tick, bit_tick, div_err, count, os_cnt
`ifdef BAUD_MID_TICK_EN
    , mid_tick
`endif
  );

endinterface

// File: rtl/baud_mod_cnt.sv
// Generic modulo-N counter with enable, sync/async clear and a wrap pulse.
// n is one bit wider than the value so N = 2**W fits; n = 0 never wraps.
module baud_mod_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   n,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = en && ({1'b0, value} == (n - 1'b1));

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: divisor prescaler feeding an OSR-wide oversample counter.
// Optional BAUD_MID_TICK_EN adds a registered mid-bit sampling pulse (mid_tick).
//
// state | meaning
// IDLE  | stopped; counters hold, ticks low; div_q latched on leaving if empty
// RUN   | prescaler counts every enabled edge; pending divisor applied on wrap
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OSR   = OSR_DEF
) (
  input logic           clk,
  input logic           rst_async,
  input logic           rst_sync,
  baud_tick_gen_if.slave bus
);
  localparam int OS_W = os_width(OSR);
  localparam logic [OS_W:0]   OS_N   = OSR[OS_W:0];
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OSR / 2 - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_q, div_q_nxt, div_pend;
  logic             pend_vld;
  logic             run_en, cnt_clr, ps_wrap, os_wrap;
  logic [CNT_W-1:0] count;
  logic [OS_W-1:0]  os_cnt;
  logic             os_tick, bit_tick, div_err;

  // A zero divisor can only reach RUN through a pending load; park and clear then.
  assign run_en  = (state == RUN) && bus.en && (div_q != '0);
  assign cnt_clr = rst_sync || ((state == RUN) && (div_q == '0));

  baud_mod_cnt #(.W(CNT_W)) u_prescale (
    .clk       (clk),
    .rst_async (rst_async),
    .clr       (cnt_clr),
    .en        (run_en),
    .n         ({1'b0, div_q}),
    .value     (count),
    .wrap      (ps_wrap)
  );

  baud_mod_cnt #(.W(OS_W)) u_oversample (
    .clk       (clk),
    .rst_async (rst_async),
    .clr       (cnt_clr),
    .en        (ps_wrap),
    .n         (OS_N),
    .value     (os_cnt),
    .wrap      (os_wrap)
  );

  // Resuming keeps the held div_q; only an empty div_q takes the input divisor.
  always_comb begin
    state_nxt = state;
    div_q_nxt = div_q;
    case (state)
      IDLE: begin
        if (bus.en && ((div_q != '0) || (bus.divisor != '0))) begin
          state_nxt = RUN;
          if (div_q == '0) div_q_nxt = bus.divisor;
        end
      end
      RUN: begin
        if (!bus.en || (div_q == '0)) state_nxt = IDLE;
        else if (ps_wrap && pend_vld) div_q_nxt = div_pend;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state    <= IDLE;
      div_q    <= '0;
      div_pend <= '0;
      pend_vld <= 1'b0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      div_err  <= 1'b1;
    end else if (rst_sync) begin
      state    <= IDLE;
      div_q    <= '0;
      div_pend <= '0;
      pend_vld <= 1'b0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      div_err  <= 1'b1;
    end else begin
      state    <= state_nxt;
      div_q    <= div_q_nxt;
      div_err  <= (div_q_nxt == '0);
      os_tick  <= ps_wrap;
      bit_tick <= os_wrap;
      if ((state == RUN) && bus.load) begin
        div_pend <= bus.divisor;
        pend_vld <= 1'b1;
      end else if (ps_wrap) begin
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef BAUD_MID_TICK_EN
  logic mid_tick;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      mid_tick <= 1'b0;
    end else if (rst_sync) begin
      mid_tick <= 1'b0;
    end else begin
      mid_tick <= ps_wrap && (os_cnt == OS_MID);
    end
  end

  assign bus.mid_tick = mid_tick;
`endif

  assign bus.os_tick  = os_tick;
  assign bus.bit_tick = bit_tick;
  assign bus.div_err  = div_err;
  assign bus.count    = count;
  assign bus.os_cnt   = os_cnt;

endmodule
